// File: rtl/bp_pkg.sv
// Branch-predictor shared types and the history shift helper.
// Shared by the GHR, its checkpoint ring and the predictor index logic.
package bp_pkg;

  localparam int BP_HIST_W     = 9;
  localparam int BP_CKPT_DEPTH = 4;
  localparam int BP_ID_W       = $clog2(BP_CKPT_DEPTH);

  typedef logic [BP_HIST_W-1:0] hist_t;
  typedef logic [BP_ID_W-1:0]   ckpt_id_t;

  function automatic hist_t hist_shift(
    input hist_t h,
    input logic  b
  );
    return {b, h[BP_HIST_W-1:1]};
  endfunction

endpackage

// File: rtl/ghr_ckpt_ring.sv
// Checkpoint ring: per-branch pre-shift history, valid/resolved/outcome
// state and head/tail pointers carrying a wrap bit to tell full from empty.
module ghr_ckpt_ring
  import bp_pkg::*;
#(
  parameter int HIST_W = BP_HIST_W,
  parameter int DEPTH  = BP_CKPT_DEPTH,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              alloc,
  input  logic [HIST_W-1:0] alloc_hist,
  output logic [ID_W-1:0]   tail_id,
  output logic [ID_W:0]     count,
  input  logic              resolve,
  input  logic [ID_W-1:0]   res_id,
  input  logic              res_taken,
  input  logic              truncate,
  output logic              live,
  output logic [HIST_W-1:0] res_ckpt,
  input  logic              retire,
  output logic              retire_ok,
  output logic              retire_taken
);

  logic [HIST_W-1:0] ckpt [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  resolved;
  logic [DEPTH-1:0]  outcome;
  logic [ID_W:0]     head;
  logic [ID_W:0]     tail;
  logic [ID_W-1:0]   head_id;
  logic [ID_W-1:0]   id_off;
  logic [DEPTH-1:0]  younger;

  assign head_id      = head[ID_W-1:0];
  assign tail_id      = tail[ID_W-1:0];
  assign count        = tail - head;
  assign live         = valid[res_id];
  assign res_ckpt     = ckpt[res_id];
  assign retire_ok    = valid[head_id] & resolved[head_id];
  assign retire_taken = outcome[head_id];
  assign id_off       = res_id - head_id;

  // Age is the modular distance from head; younger = further than res_id.
  always_comb begin
    younger = '0;
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = (ID_W'(i) - head_id) > id_off;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid    <= '0;
      resolved <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (alloc) begin
        valid[tail_id]    <= 1'b1;
        resolved[tail_id] <= 1'b0;
        tail              <= tail + 1'b1;
      end
      if (resolve) begin
        resolved[res_id] <= 1'b1;
      end
      if (truncate) begin
        valid <= valid & ~younger;
        tail  <= head + {1'b0, id_off} + 1'b1;
      end
      if (retire) begin
        valid[head_id] <= 1'b0;
        head           <= head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc && !reset && !clear) begin
      ckpt[tail_id] <= alloc_hist;
    end
    if (resolve && !reset && !clear) begin
      outcome[res_id] <= res_taken;
    end
  end

endmodule

// File: rtl/spec_history_register.sv
// Speculative global history register with per-branch checkpoints,
// mispredict repair, flush and a separately tracked retired history.
module spec_history_register
  import bp_pkg::*;
#(
  parameter int HIST_W     = BP_HIST_W,
  parameter int CKPT_DEPTH = BP_CKPT_DEPTH,
  localparam int ID_W      = $clog2(CKPT_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic              push_taken,
  output logic              push_ready,
  output logic [ID_W-1:0]   push_id,
  input  logic              resolve_valid,
  input  logic [ID_W-1:0]   resolve_id,
  input  logic              resolve_taken,
  input  logic              resolve_mispred,
  input  logic              flush,
  output logic [HIST_W-1:0] spec_hist,
  output logic [HIST_W-1:0] commit_hist,
  output logic              err
);

  function automatic logic [HIST_W-1:0] shift(
    input logic [HIST_W-1:0] h,
    input logic              b
  );
    return {b, h[HIST_W-1:1]};
  endfunction

  logic [ID_W:0]     count;
  logic              live;
  logic [HIST_W-1:0] res_ckpt;
  logic              retire_ok;
  logic              retire_taken;
  logic              do_push;
  logic              do_resolve;
  logic              do_mispred;
  logic [HIST_W-1:0] commit_nxt;
  logic [HIST_W-1:0] spec_nxt;

  // Count never exceeds the depth, so its top bit alone means full.
  assign push_ready = ~count[ID_W];

  assign do_push = push_valid & push_ready & ~flush
                 & ~(resolve_valid & resolve_mispred);
  assign do_resolve = resolve_valid & live & ~flush;
  assign do_mispred = do_resolve & resolve_mispred;

  always_comb begin
    commit_nxt = commit_hist;
    if (retire_ok) begin
      commit_nxt = shift(commit_hist, retire_taken);
    end
  end

  always_comb begin
    spec_nxt = spec_hist;
    unique case (1'b1)
      flush:      spec_nxt = commit_nxt;
      do_mispred: spec_nxt = shift(res_ckpt, resolve_taken);
      do_push:    spec_nxt = shift(spec_hist, push_taken);
      default:    spec_nxt = spec_hist;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_hist   <= '0;
      commit_hist <= '0;
      err         <= 1'b0;
    end else begin
      spec_hist   <= spec_nxt;
      commit_hist <= commit_nxt;
      err         <= resolve_valid & ~live & ~flush;
    end
  end

  ghr_ckpt_ring #(
    .HIST_W (HIST_W),
    .DEPTH  (CKPT_DEPTH)
  ) u_ring (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush),
    .alloc        (do_push),
    .alloc_hist   (spec_hist),
    .tail_id      (push_id),
    .count        (count),
    .resolve      (do_resolve),
    .res_id       (resolve_id),
    .res_taken    (resolve_taken),
    .truncate     (do_mispred),
    .live         (live),
    .res_ckpt     (res_ckpt),
    .retire       (retire_ok),
    .retire_ok    (retire_ok),
    .retire_taken (retire_taken)
  );

endmodule

// File: tb/tb_spec_history_register.sv
// Bench for spec_history_register: directed vector table, reset
// mid-operation, then random traffic against a queue-based model.
module tb_spec_history_register;

  logic       clk;
  logic       reset;
  logic       push_valid;
  logic       push_taken;
  logic       push_ready;
  logic [1:0] push_id;
  logic       resolve_valid;
  logic [1:0] resolve_id;
  logic       resolve_taken;
  logic       resolve_mispred;
  logic       flush;
  logic [8:0] spec_hist;
  logic [8:0] commit_hist;
  logic       err;

  int n_tot;
  int n_pass;

  spec_history_register dut (
    .clk             (clk),
    .reset           (reset),
    .push_valid      (push_valid),
    .push_taken      (push_taken),
    .push_ready      (push_ready),
    .push_id         (push_id),
    .resolve_valid   (resolve_valid),
    .resolve_id      (resolve_id),
    .resolve_taken   (resolve_taken),
    .resolve_mispred (resolve_mispred),
    .flush           (flush),
    .spec_hist       (spec_hist),
    .commit_hist     (commit_hist),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  typedef struct {
    logic pv, pt, rv;
    logic [1:0] rid;
    logic rt, rm, fl;
    logic rdy;
    logic [1:0] pid;
    logic [8:0] sp, cm;
    logic er;
  } vec_t;

  function automatic vec_t mk(
    input logic pv, pt, rv,
    input logic [1:0] rid,
    input logic rt, rm, fl, rdy,
    input logic [1:0] pid,
    input logic [8:0] sp, cm,
    input logic er
  );
    vec_t v;
    v.pv = pv; v.pt = pt; v.rv = rv; v.rid = rid;
    v.rt = rt; v.rm = rm; v.fl = fl; v.rdy = rdy;
    v.pid = pid; v.sp = sp; v.cm = cm; v.er = er;
    return v;
  endfunction

  task automatic drive(
    input logic pv, pt, rv,
    input logic [1:0] rid,
    input logic rt, rm, fl, rst
  );
    push_valid = pv; push_taken = pt;
    resolve_valid = rv; resolve_id = rid;
    resolve_taken = rt; resolve_mispred = rm;
    flush = fl; reset = rst;
  endtask

  // Reference model: list of in-flight branches, oldest first.
  typedef struct {
    int         id;
    logic [8:0] ck;
    bit         res;
    bit         out;
  } ent_t;

  ent_t       q[$];
  int         m_tail;
  logic [8:0] m_spec;
  logic [8:0] m_commit;
  logic       m_err;

  function automatic logic [8:0] hs(input logic [8:0] h, input bit b);
    return (h >> 1) | (b ? 9'h100 : 9'h000);
  endfunction

  function automatic void m_reset();
    q.delete();
    m_tail = 0; m_spec = '0; m_commit = '0; m_err = 1'b0;
  endfunction

  function automatic void m_step(
    input bit pv, pt, rv,
    input int rid,
    input bit rt, rm, fl, rst
  );
    bit ready, ret, rout;
    int k;
    if (rst) begin
      m_reset();
      return;
    end
    ready = q.size() < 4;
    ret   = q.size() > 0 && q[0].res;
    rout  = ret ? q[0].out : 1'b0;
    if (ret) m_commit = hs(m_commit, rout);
    if (fl) begin
      m_spec = m_commit;
      q.delete();
      m_tail = 0;
      m_err = 1'b0;
      return;
    end
    k = -1;
    foreach (q[i]) if (q[i].id == rid) k = i;
    m_err = rv && k < 0;
    if (rv && k >= 0) begin
      q[k].res = 1'b1;
      q[k].out = rt;
      if (rm) begin
        m_spec = hs(q[k].ck, rt);
        while (q.size() > k + 1) void'(q.pop_back());
        m_tail = (rid + 1) % 4;
      end
    end
    if (ret) void'(q.pop_front());
    if (pv && ready && !(rv && rm)) begin
      q.push_back('{id: m_tail, ck: m_spec, res: 0, out: 0});
      m_spec = hs(m_spec, pt);
      m_tail = (m_tail + 1) % 4;
    end
  endfunction

  vec_t tbl[26];

  initial begin
    n_tot = 0;
    n_pass = 0;
    tbl[0]  = mk(1,1,0,0,0,0,0, 1,0,9'h100,9'h000,0);
    tbl[1]  = mk(1,1,0,0,0,0,0, 1,1,9'h180,9'h000,0);
    tbl[2]  = mk(1,0,0,0,0,0,0, 1,2,9'h0C0,9'h000,0);
    tbl[3]  = mk(1,1,0,0,0,0,0, 1,3,9'h160,9'h000,0);
    tbl[4]  = mk(1,1,0,0,0,0,0, 0,0,9'h160,9'h000,0);
    tbl[5]  = mk(0,0,0,0,0,0,1, 0,0,9'h000,9'h000,0);
    tbl[6]  = mk(1,1,0,0,0,0,0, 1,0,9'h100,9'h000,0);
    tbl[7]  = mk(1,1,0,0,0,0,0, 1,1,9'h180,9'h000,0);
    tbl[8]  = mk(1,1,0,0,0,0,0, 1,2,9'h1C0,9'h000,0);
    tbl[9]  = mk(0,0,1,1,0,1,0, 1,3,9'h080,9'h000,0);
    tbl[10] = mk(0,0,0,0,0,0,0, 1,2,9'h080,9'h000,0);
    tbl[11] = mk(0,0,1,2,0,0,0, 1,2,9'h080,9'h000,1);
    tbl[12] = mk(0,0,0,0,0,0,0, 1,2,9'h080,9'h000,0);
    tbl[13] = mk(0,0,1,0,1,0,0, 1,2,9'h080,9'h000,0);
    tbl[14] = mk(0,0,0,0,0,0,0, 1,2,9'h080,9'h100,0);
    tbl[15] = mk(0,0,0,0,0,0,0, 1,2,9'h080,9'h080,0);
    tbl[16] = mk(1,1,0,0,0,0,0, 1,2,9'h140,9'h080,0);
    tbl[17] = mk(1,1,0,0,0,0,0, 1,3,9'h1A0,9'h080,0);
    tbl[18] = mk(1,1,1,3,0,1,0, 1,0,9'h0A0,9'h080,0);
    tbl[19] = mk(0,0,0,0,0,0,0, 1,0,9'h0A0,9'h080,0);
    tbl[20] = mk(1,0,0,0,0,0,0, 1,0,9'h050,9'h080,0);
    tbl[21] = mk(0,0,0,0,0,0,1, 1,1,9'h080,9'h080,0);
    tbl[22] = mk(0,0,0,0,0,0,0, 1,0,9'h080,9'h080,0);
    tbl[23] = mk(1,1,0,0,0,0,0, 1,0,9'h140,9'h080,0);
    tbl[24] = mk(0,0,1,0,0,1,0, 1,1,9'h040,9'h080,0);
    tbl[25] = mk(0,0,0,0,0,0,0, 1,1,9'h040,9'h040,0);

    drive(0,0,0,0,0,0,0,1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    #1;
    check("rst_spec", 32'(spec_hist), 0);
    check("rst_commit", 32'(commit_hist), 0);
    check("rst_ready", 32'(push_ready), 1);
    check("rst_id", 32'(push_id), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rid,
            tbl[i].rt, tbl[i].rm, tbl[i].fl, 1'b0);
      #1;
      check($sformatf("v%0d_ready", i), 32'(push_ready), 32'(tbl[i].rdy));
      check($sformatf("v%0d_id", i), 32'(push_id), 32'(tbl[i].pid));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_spec", i), 32'(spec_hist), 32'(tbl[i].sp));
      check($sformatf("v%0d_commit", i), 32'(commit_hist), 32'(tbl[i].cm));
      check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
      @(negedge clk);
    end

    // Reset in the middle of traffic, with a push pending.
    drive(1,1,0,0,0,0,0,0);
    @(posedge clk);
    #1;
    check("mid_spec_pre", 32'(spec_hist), 32'h120);
    @(negedge clk);
    drive(1,1,1,1,1,0,0,1);
    @(posedge clk);
    #1;
    check("mid_rst_spec", 32'(spec_hist), 0);
    check("mid_rst_commit", 32'(commit_hist), 0);
    check("mid_rst_err", 32'(err), 0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    #1;
    check("mid_rst_ready", 32'(push_ready), 1);
    check("mid_rst_id", 32'(push_id), 0);
    m_reset();

    for (int c = 0; c < 600; c++) begin
      bit pv, pt, rv, rt, rm, fl, rst;
      int rid;
      pv  = $urandom_range(0, 3) != 0;
      pt  = $urandom_range(0, 1) != 0;
      rv  = $urandom_range(0, 1) != 0;
      rt  = $urandom_range(0, 1) != 0;
      rm  = $urandom_range(0, 9) < 3;
      fl  = $urandom_range(0, 29) == 0;
      rst = $urandom_range(0, 99) == 0;
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        rid = q[$urandom_range(0, q.size() - 1)].id;
      else
        rid = $urandom_range(0, 3);
      drive(pv, pt, rv, 2'(rid), rt, rm, fl, rst);
      #1;
      check("rnd_ready", 32'(push_ready), 32'(q.size() < 4));
      check("rnd_id", 32'(push_id), 32'(m_tail));
      m_step(pv, pt, rv, rid, rt, rm, fl, rst);
      @(posedge clk);
      #1;
      check("rnd_spec", 32'(spec_hist), 32'(m_spec));
      check("rnd_commit", 32'(commit_hist), 32'(m_commit));
      check("rnd_err", 32'(err), 32'(m_err));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
